// File: rtl/mas_mul_vedic_pipe_pkg.sv
// mas_mul_pkg: shared types and elaboration helpers for the pipelined Vedic multiplier
package mas_mul_pkg;
    typedef enum logic {MODE_UNSIGNED = 1'b0, MODE_SIGNED = 1'b1} mode_e;
    function automatic bit is_pow2(int v);
        return v > 0 && (v & (v - 1)) == 0;
    endfunction
endpackage

// File: rtl/mas_mul_vedic_pipe_if.sv
// mas_mul_vedic_pipe_if: operand/result valid-ready bundle for the Vedic multiplier
interface mas_mul_vedic_pipe_if #(parameter int WIDTH = 8, parameter int TAG_W = 4);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               in_signed;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] res;
    logic [TAG_W-1:0]   out_tag;
    modport master (output in_valid, in1, in2, in_signed, in_tag, out_ready,
                    input in_ready, out_valid, res, out_tag);
    modport slave (input in_valid, in1, in2, in_signed, in_tag, out_ready,
                   output in_ready, out_valid, res, out_tag);
endinterface

// File: rtl/mas_mul_vedic_nxn.sv
// mas_mul_vedic_nxn: recursive combinational Urdhva-Tiryagbhyam N x N unsigned multiplier
module mas_mul_vedic_nxn #(parameter int N = 4) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    if (N == 2) begin : g_base
        logic c_lo, c_hi, k, hh;
        assign c_lo = a[1] & b[0];
        assign c_hi = a[0] & b[1];
        assign k    = c_lo & c_hi;
        assign hh   = a[1] & b[1];
        assign p    = {hh & k, hh ^ k, c_lo ^ c_hi, a[0] & b[0]};
    end else begin : g_rec
        localparam int H = N / 2;
        logic [N-1:0] pll, plh, phl, phh;
        logic [N:0]   mid;
        mas_mul_vedic_nxn #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pll));
        mas_mul_vedic_nxn #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(plh));
        mas_mul_vedic_nxn #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(phl));
        mas_mul_vedic_nxn #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(phh));
        // Cross sum keeps its carry so the middle column never overflows
        assign mid = {1'b0, plh} + {1'b0, phl};
        assign p   = {{N{1'b0}}, pll} + ({{(N-1){1'b0}}, mid} << H) + {phh, {N{1'b0}}};
    end
endmodule

// File: rtl/mas_mul_vedic_pipe.sv
// mas_mul_vedic_pipe: 2-stage pipelined Vedic multiplier, signed/unsigned per beat, valid/ready flow
module mas_mul_vedic_pipe
    import mas_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    mas_mul_vedic_pipe_if.slave bus
);
    localparam int H = WIDTH / 2;
    typedef struct packed {
        logic             neg;
        logic [TAG_W-1:0] tag;
    } side_t;

    if (!is_pow2(WIDTH) || WIDTH < 4) begin : g_bad_width
        $error("mas_mul_vedic_pipe: WIDTH must be a power of two >= 4");
    end

    mode_e                    mode;
    logic [WIDTH-1:0]         a_mag, b_mag;
    logic [3:0][WIDTH-1:0]    pp, pp_d, pp_q;
    side_t                    side_in, side_d, side_q;
    logic                     s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
    logic                     adv1, adv2, in_ready;
    logic [WIDTH:0]           mid;
    logic [2*WIDTH-1:0]       prod, res_d, res_q;
    logic [TAG_W-1:0]         out_tag_d, out_tag_q;

    assign mode = mode_e'(bus.in_signed);

    // Partial products: index bit 0 picks a's high half, bit 1 picks b's high half
    for (genvar i = 0; i < 4; i++) begin : g_pp
        mas_mul_vedic_nxn #(.N(H)) u_pp (
            .a (i % 2 == 1 ? a_mag[WIDTH-1:H] : a_mag[H-1:0]),
            .b (i / 2 == 1 ? b_mag[WIDTH-1:H] : b_mag[H-1:0]),
            .p (pp[i])
        );
    end

    // Sign folding, handshake decisions and next-state for both stages
    always_comb begin
        a_mag       = (mode == MODE_SIGNED && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
        b_mag       = (mode == MODE_SIGNED && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
        side_in.neg = (mode == MODE_SIGNED) && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
        side_in.tag = bus.in_tag;
        adv2        = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready    = !s1_valid_q || adv2;
        adv1        = bus.in_valid && in_ready;
        s1_valid_d  = adv1 || (s1_valid_q && !adv2);
        s2_valid_d  = adv2 || (s2_valid_q && !bus.out_ready);
        pp_d        = adv1 ? pp : pp_q;
        side_d      = adv1 ? side_in : side_q;
        mid         = {1'b0, pp_q[1]} + {1'b0, pp_q[2]};
        prod        = {{WIDTH{1'b0}}, pp_q[0]} + ({{(WIDTH-1){1'b0}}, mid} << H) + {pp_q[3], {WIDTH{1'b0}}};
        res_d       = adv2 ? (side_q.neg ? -prod : prod) : res_q;
        out_tag_d   = adv2 ? side_q.tag : out_tag_q;
    end

    // Control and output registers: reset drops every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            out_tag_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            out_tag_q  <= out_tag_d;
        end
    end

    // Stage-1 data: meaningful only while s1_valid_q is set, so no reset
    always_ff @(posedge clk) begin
        pp_q   <= pp_d;
        side_q <= side_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.res       = res_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_mas_mul_vedic_pipe.sv
// tb_mas_mul_vedic_pipe: self-checking bench for the pipelined Vedic multiplier (WIDTH 4/8/16)
module tb_mas_mul_vedic_pipe;
    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mas_mul_vedic_pipe_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();
    mas_mul_vedic_pipe_if #(.WIDTH(4),  .TAG_W(4)) bus4 ();
    mas_mul_vedic_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();

    mas_mul_vedic_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    mas_mul_vedic_pipe #(.WIDTH(4),  .TAG_W(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mas_mul_vedic_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    // Reference product of w-bit operands, reduced modulo 2**(2w)
    function automatic logic [31:0] model(logic [15:0] a, logic [15:0] b, logic s, int w);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x -= longint'(1) << w;
        if (s && b[w-1]) y -= longint'(1) << w;
        return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus4.out_valid !== 1'b0 || bus16.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b%b%b want 000", bus8.out_valid, bus4.out_valid, bus16.out_valid);
        end
        checks++;
        if (bus8.res !== 16'h0000 || bus8.out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_data got res %h tag %h want 0000 0", bus8.res, bus8.out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus8.in_ready);
        end
    endtask

    task automatic test_unsigned_max();
        @(negedge clk);
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.in1       = 8'hFF;
        bus8.in2       = 8'hFF;
        bus8.in_signed = 1'b0;
        bus8.in_tag    = 4'h5;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL umax_accept got in_ready %b want 1", bus8.in_ready);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL umax_early got out_valid %b want 0", bus8.out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.res !== 16'hFE01 || bus8.out_tag !== 4'h5) begin
            errors++;
            $display("FAIL umax_result got v %b res %h tag %h want v 1 res fe01 tag 5", bus8.out_valid, bus8.res, bus8.out_tag);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL umax_drain got out_valid %b want 0", bus8.out_valid);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  va [8];
        logic [7:0]  vb [8];
        logic        vs [8];
        logic [15:0] ve [8];
        va = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hF9, 8'h80};
        vb = '{8'h80, 8'h7F, 8'h01, 8'hFB, 8'h02, 8'h02, 8'hFD, 8'h80};
        vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        ve = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h01FE, 16'h0015, 16'h4000};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus8.out_ready = 1'b1;
            bus8.in_valid  = 1'b1;
            bus8.in1       = va[i];
            bus8.in2       = vb[i];
            bus8.in_signed = vs[i];
            bus8.in_tag    = 4'(i);
            @(negedge clk);
            bus8.in_valid = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (bus8.out_valid !== 1'b1 || bus8.res !== ve[i] || bus8.out_tag !== 4'(i)) begin
                errors++;
                $display("FAIL signed_%0d got v %b res %h tag %h want v 1 res %h tag %h", i, bus8.out_valid, bus8.res, bus8.out_tag, ve[i], 4'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q_res [$];
        logic [3:0]  q_tag [$];
        logic [15:0] er;
        logic [3:0]  et;
        int n = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus8.out_ready = 1'b1;
            bus8.in_valid  = c < 10;
            bus8.in1       = 8'(c * 37 + 3);
            bus8.in2       = 8'(c * 19 + 250);
            bus8.in_signed = c[0];
            bus8.in_tag    = 4'(c);
            #1;
            if (bus8.out_valid) begin
                if (first < 0) first = c;
                last = c;
                n++;
                checks++;
                if (q_res.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got res %h want no output", bus8.res);
                end else begin
                    er = q_res.pop_front();
                    et = q_tag.pop_front();
                    if (bus8.res !== er || bus8.out_tag !== et) begin
                        errors++;
                        $display("FAIL b2b_value got res %h tag %h want res %h tag %h", bus8.res, bus8.out_tag, er, et);
                    end
                end
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q_res.push_back(16'(model(16'(bus8.in1), 16'(bus8.in2), bus8.in_signed, 8)));
                q_tag.push_back(bus8.in_tag);
            end
        end
        checks++;
        if (n != 10 || last - first != 9) begin
            errors++;
            $display("FAIL b2b_stream got %0d beats over %0d cycles want 10 over 10", n, last - first + 1);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.in1       = 8'd3;
        bus8.in2       = 8'd5;
        bus8.in_signed = 1'b0;
        bus8.in_tag    = 4'd1;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept_a got in_ready %b want 1", bus8.in_ready);
        end
        @(negedge clk);
        bus8.in1       = 8'hFE;
        bus8.in2       = 8'd7;
        bus8.in_signed = 1'b1;
        bus8.in_tag    = 4'd2;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept_b got in_ready %b want 1", bus8.in_ready);
        end
        @(negedge clk);
        bus8.in1       = 8'd200;
        bus8.in2       = 8'd100;
        bus8.in_signed = 1'b0;
        bus8.in_tag    = 4'd3;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (bus8.in_ready !== 1'b0 || bus8.out_valid !== 1'b1 || bus8.res !== 16'h000F || bus8.out_tag !== 4'd1) begin
                errors++;
                $display("FAIL stall_hold_%0d got rdy %b v %b res %h tag %h want rdy 0 v 1 res 000f tag 1", i, bus8.in_ready, bus8.out_valid, bus8.res, bus8.out_tag);
            end
        end
        @(negedge clk);
        bus8.out_ready = 1'b1;
        #1;
        checks++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b1 || bus8.res !== 16'h000F) begin
            errors++;
            $display("FAIL stall_release got rdy %b v %b res %h want rdy 1 v 1 res 000f", bus8.in_ready, bus8.out_valid, bus8.res);
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.res !== 16'hFFF2 || bus8.out_tag !== 4'd2) begin
            errors++;
            $display("FAIL stall_drain_b got v %b res %h tag %h want v 1 res fff2 tag 2", bus8.out_valid, bus8.res, bus8.out_tag);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.res !== 16'h4E20 || bus8.out_tag !== 4'd3) begin
            errors++;
            $display("FAIL stall_drain_c got v %b res %h tag %h want v 1 res 4e20 tag 3", bus8.out_valid, bus8.res, bus8.out_tag);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.res !== 16'h4E20) begin
            errors++;
            $display("FAIL stall_empty got v %b res %h want v 0 res 4e20", bus8.out_valid, bus8.res);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        bus8.in1       = 8'd9;
        bus8.in2       = 8'd9;
        bus8.in_signed = 1'b0;
        bus8.in_tag    = 4'hA;
        @(negedge clk);
        bus8.in1    = 8'd7;
        bus8.in2    = 8'd6;
        bus8.in_tag = 4'hB;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.res !== 16'd81) begin
            errors++;
            $display("FAIL rst_inflight got v %b res %h want v 1 res 0051", bus8.out_valid, bus8.res);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.out_valid !== 1'b0 || bus8.res !== 16'h0000) begin
            errors++;
            $display("FAIL rst_async got v %b res %h want v 0 res 0000", bus8.out_valid, bus8.res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_after_%0d got out_valid %b want 0", i, bus8.out_valid);
            end
        end
    endtask

    task automatic test_random_w4();
        logic [7:0] q_res [$];
        logic [3:0] q_tag [$];
        logic [7:0] er;
        logic [3:0] et;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < NRAND && cyc < 30000) begin
            @(negedge clk);
            bus4.in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            bus4.in1       = 4'($urandom);
            bus4.in2       = 4'($urandom);
            bus4.in_signed = 1'($urandom);
            bus4.in_tag    = 4'($urandom);
            bus4.out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (bus4.out_valid && bus4.out_ready) begin
                checks++;
                got++;
                if (q_res.size() == 0) begin
                    errors++;
                    $display("FAIL w4_extra got res %h want no output", bus4.res);
                end else begin
                    er = q_res.pop_front();
                    et = q_tag.pop_front();
                    if (bus4.res !== er || bus4.out_tag !== et) begin
                        errors++;
                        $display("FAIL w4_random got res %h tag %h want res %h tag %h", bus4.res, bus4.out_tag, er, et);
                    end
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                q_res.push_back(8'(model(16'(bus4.in1), 16'(bus4.in2), bus4.in_signed, 4)));
                q_tag.push_back(bus4.in_tag);
                sent++;
            end
            cyc++;
        end
        bus4.in_valid = 1'b0;
        checks++;
        if (got != NRAND) begin
            errors++;
            $display("FAIL w4_timeout got %0d results want %0d", got, NRAND);
        end
    endtask

    task automatic test_random_w16();
        logic [31:0] q_res [$];
        logic [3:0]  q_tag [$];
        logic [31:0] er;
        logic [3:0]  et;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < NRAND && cyc < 30000) begin
            @(negedge clk);
            bus16.in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            bus16.in1       = 16'($urandom);
            bus16.in2       = 16'($urandom);
            bus16.in_signed = 1'($urandom);
            bus16.in_tag    = 4'($urandom);
            bus16.out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (bus16.out_valid && bus16.out_ready) begin
                checks++;
                got++;
                if (q_res.size() == 0) begin
                    errors++;
                    $display("FAIL w16_extra got res %h want no output", bus16.res);
                end else begin
                    er = q_res.pop_front();
                    et = q_tag.pop_front();
                    if (bus16.res !== er || bus16.out_tag !== et) begin
                        errors++;
                        $display("FAIL w16_random got res %h tag %h want res %h tag %h", bus16.res, bus16.out_tag, er, et);
                    end
                end
            end
            if (bus16.in_valid && bus16.in_ready) begin
                q_res.push_back(model(bus16.in1, bus16.in2, bus16.in_signed, 16));
                q_tag.push_back(bus16.in_tag);
                sent++;
            end
            cyc++;
        end
        bus16.in_valid = 1'b0;
        checks++;
        if (got != NRAND) begin
            errors++;
            $display("FAIL w16_timeout got %0d results want %0d", got, NRAND);
        end
    endtask

    initial begin
        bus8.in_valid   = 1'b0;
        bus8.in1        = '0;
        bus8.in2        = '0;
        bus8.in_signed  = 1'b0;
        bus8.in_tag     = '0;
        bus8.out_ready  = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.in1        = '0;
        bus4.in2        = '0;
        bus4.in_signed  = 1'b0;
        bus4.in_tag     = '0;
        bus4.out_ready  = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.in1       = '0;
        bus16.in2       = '0;
        bus16.in_signed = 1'b0;
        bus16.in_tag    = '0;
        bus16.out_ready = 1'b0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random_w4();
        test_random_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
